// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: round-robin grant in IDLE,
// lock-hold ownership, combinational memory drive and one-cycle registered read return.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo
);

  // state | meaning
  // IDLE  | no lock held; round-robin between requesters
  // OWN_A | A holds the lock; only A may be granted
  // OWN_B | B holds the lock; only B may be granted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_b;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic [ADDR_W-1:0] r_hold_a;
  logic [DATA_W-1:0] r_hold_d;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req && b_req) begin
          // r_last_b low means A went last, so B wins the tie
          w_a_gnt = r_last_b;
          w_b_gnt = ~r_last_b;
        end else begin
          w_a_gnt = a_req;
          w_b_gnt = b_req;
        end
        if (w_a_gnt && a_lock) begin
          w_next_state = OWN_A;
        end else if (w_b_gnt && b_lock) begin
          w_next_state = OWN_B;
        end
      end
      OWN_A: begin
        w_a_gnt = a_req;
        if (!a_req || !a_lock) begin
          w_next_state = IDLE;
        end
      end
      OWN_B: begin
        w_b_gnt = b_req;
        if (!b_req || !b_lock) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    // No grant, and therefore no memory write, may escape while reset is held
    w_a_gnt = w_a_gnt & rstn;
    w_b_gnt = w_b_gnt & rstn;
  end

  assign a_gnt  = w_a_gnt;
  assign b_gnt  = w_b_gnt;
  assign mem_we = (w_a_gnt & a_we) | (w_b_gnt & b_we);
  assign mem_a  = w_a_gnt ? a_addr  : (w_b_gnt ? b_addr  : r_hold_a);
  assign mem_d  = w_a_gnt ? a_wdata : (w_b_gnt ? b_wdata : r_hold_d);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_b <= 1'b0;
      r_hold_a <= '0;
      r_hold_d <= '0;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
      r_hold_a <= a_addr;
      r_hold_d <= a_wdata;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
      r_hold_a <= b_addr;
      r_hold_d <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
      if (w_a_gnt && !a_we) begin
        r_a_rdata <= mem_spo;
      end
      if (w_b_gnt && !b_we) begin
        r_b_rdata <= mem_spo;
      end
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rvalid = r_b_rvalid;
  assign b_rdata  = r_b_rdata;

endmodule
